// File: rtl/drv_audio_i2s_slave_if.sv
// Stream side of the slave I2S port: TX words toward the pads, RX words from the pads.
// Both directions are fire-and-forget pulses; the pad timing sets the pace.
interface drv_audio_i2s_slave_if #(
    parameter int p_width = 16
);
    // Handshake: there is no backpressure. o_ack pulses for one cycle when i_dat is
    // captured at a frame start, so i_dat must already hold the next frame's words;
    // o_req pulses for one cycle in the same cycle that o_dat first shows a new frame.
    logic [1:0][p_width-1:0] i_dat;
    logic                    o_ack;
    logic [1:0][p_width-1:0] o_dat;
    logic                    o_req;

    modport master (output i_dat, input o_ack, input o_dat, input o_req);
    modport slave  (input i_dat, output o_ack, output o_dat, output o_req);
endinterface

// File: rtl/drv_audio_i2s_slave.sv
// Slave-side I2S / left-justified port: BCLK and LRCK come from an external master,
// stereo words are deserialised from SDIN and serialised onto SDOUT.
module drv_audio_i2s_slave #(
    parameter int p_width = 16,
    parameter int p_delay = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_drv_bclk,
    input  logic i_drv_lrck,
    input  logic i_drv_sdin,
    output logic o_drv_sdout,
    drv_audio_i2s_slave_if.slave strm
);
    // Bit counters hold (bit index + p_delay) so they never go negative.
    localparam int                 CW      = $clog2(p_width + p_delay + 1);
    localparam logic [CW-1:0]      CNT_MAX = CW'(p_width + p_delay);
    localparam logic [CW-1:0]      CNT_OFS = CW'(p_delay);
    localparam logic [CW-1:0]      WIDTH_C = CW'(p_width);
    localparam logic [CW-1:0]      MSB_IDX = CW'(p_width - 1);
    localparam logic [p_width-1:0] LSB_ONE = {{(p_width-1){1'b0}}, 1'b1};

    typedef logic [1:0][p_width-1:0] pair_t;

    // One-hot mask of the word bit addressed by a counter; zero outside the data slots.
    function automatic logic [p_width-1:0] slot_mask(input logic [CW-1:0] cnt);
        logic [CW-1:0] rel;
        rel = cnt - CNT_OFS;
        slot_mask = (rel < WIDTH_C) ? (LSB_ONE << (MSB_IDX - rel)) : '0;
    endfunction

    logic [2:0] bclk_q;
    logic [1:0] lrck_q;
    logic [1:0] sdin_q;
    logic       bclk_rise, bclk_fall, lrck_s, sdin_s;

    logic               rx_lr_prev_q, rx_lr_prev_d;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    pair_t              rx_word_q, rx_word_d;
    logic               locked_q, locked_d;
    pair_t              dat_q, dat_d;
    logic               req_q, req_d;
    logic [p_width-1:0] rx_mask;

    logic               tx_lr_prev_q, tx_lr_prev_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [p_width-1:0] tx_word_q, tx_word_d;
    pair_t              tx_buf_q, tx_buf_d;
    logic               ack_q, ack_d;
    logic               sdout_q, sdout_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_q <= '0;
            lrck_q <= '0;
            sdin_q <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], i_drv_bclk};
            lrck_q <= {lrck_q[0], i_drv_lrck};
            sdin_q <= {sdin_q[0], i_drv_sdin};
        end
    end

    // LRCK/SDIN use the same sync depth as BCLK so they line up with the strobes.
    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign bclk_fall = ~bclk_q[1] & bclk_q[2];
    assign lrck_s    = lrck_q[1];
    assign sdin_s    = sdin_q[1];

    always_comb begin
        rx_lr_prev_d = rx_lr_prev_q;
        rx_cnt_d     = rx_cnt_q;
        rx_word_d    = rx_word_q;
        locked_d     = locked_q;
        dat_d        = dat_q;
        req_d        = 1'b0;
        rx_mask      = '0;
        if (bclk_rise) begin
            rx_lr_prev_d = lrck_s;
            if (lrck_s != rx_lr_prev_q) begin
                rx_cnt_d          = '0;
                rx_word_d[lrck_s] = '0;
                if (!lrck_s) begin
                    // First 1->0 only arms the lock; the frame before it may be partial.
                    if (locked_q) begin
                        dat_d = rx_word_q;
                        req_d = 1'b1;
                    end
                    locked_d = 1'b1;
                end
            end else if (rx_cnt_q != CNT_MAX) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
            rx_mask = slot_mask(rx_cnt_d);
            rx_word_d[lrck_s] = sdin_s ? (rx_word_d[lrck_s] | rx_mask)
                                       : (rx_word_d[lrck_s] & ~rx_mask);
        end
    end

    always_comb begin
        tx_lr_prev_d = tx_lr_prev_q;
        tx_cnt_d     = tx_cnt_q;
        tx_word_d    = tx_word_q;
        tx_buf_d     = tx_buf_q;
        ack_d        = 1'b0;
        sdout_d      = sdout_q;
        if (bclk_fall) begin
            tx_lr_prev_d = lrck_s;
            if (lrck_s != tx_lr_prev_q) begin
                tx_cnt_d = '0;
                if (!lrck_s) begin
                    // Channel 0 takes the fresh word directly so the new frame uses it.
                    tx_buf_d  = strm.i_dat;
                    tx_word_d = strm.i_dat[0];
                    ack_d     = 1'b1;
                end else begin
                    tx_word_d = tx_buf_q[1];
                end
            end else if (tx_cnt_q != CNT_MAX) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
            sdout_d = |(tx_word_d & slot_mask(tx_cnt_d));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_lr_prev_q <= 1'b0;
            rx_cnt_q     <= '0;
            rx_word_q    <= '0;
            locked_q     <= 1'b0;
            dat_q        <= '0;
            req_q        <= 1'b0;
            tx_lr_prev_q <= 1'b0;
            tx_cnt_q     <= '0;
            tx_word_q    <= '0;
            tx_buf_q     <= '0;
            ack_q        <= 1'b0;
            sdout_q      <= 1'b0;
        end else begin
            rx_lr_prev_q <= rx_lr_prev_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_word_q    <= rx_word_d;
            locked_q     <= locked_d;
            dat_q        <= dat_d;
            req_q        <= req_d;
            tx_lr_prev_q <= tx_lr_prev_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_word_q    <= tx_word_d;
            tx_buf_q     <= tx_buf_d;
            ack_q        <= ack_d;
            sdout_q      <= sdout_d;
        end
    end

    assign o_drv_sdout = sdout_q;
    assign strm.o_dat  = dat_q;
    assign strm.o_req  = req_q;
    assign strm.o_ack  = ack_q;
endmodule

// File: tb/tb_drv_audio_i2s_slave.sv
// Bench for drv_audio_i2s_slave: one left-justified and one I2S instance share the pads;
// a master model plays frames from a vector table and checks both stream directions.
module tb_drv_audio_i2s_slave;
    localparam int W    = 16;
    localparam int HALF = 170;  // half BCLK period = 17 i_clk cycles

    typedef struct {
        logic [W-1:0] rx0;
        logic [W-1:0] rx1;
        logic [W-1:0] tx0;
        logic [W-1:0] tx1;
        int           slot;
        int           dly;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       bclk;
    logic       lrck;
    logic       sdin;
    logic [1:0] sdout;

    drv_audio_i2s_slave_if #(.p_width(W)) if0 ();
    drv_audio_i2s_slave_if #(.p_width(W)) if1 ();

    drv_audio_i2s_slave #(.p_width(W), .p_delay(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_drv_bclk(bclk), .i_drv_lrck(lrck),
        .i_drv_sdin(sdin), .o_drv_sdout(sdout[0]), .strm(if0)
    );

    drv_audio_i2s_slave #(.p_width(W), .p_delay(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_drv_bclk(bclk), .i_drv_lrck(lrck),
        .i_drv_sdin(sdin), .o_drv_sdout(sdout[1]), .strm(if1)
    );

    always #5 i_clk = ~i_clk;

    int           checks      = 0;
    int           failures    = 0;
    int           req_cnt [2] = '{0, 0};
    int           ack_cnt [2] = '{0, 0};
    logic [31:0]  last_dat [2] = '{32'h0, 32'h0};
    logic [31:0]  exp_q [$];
    logic [W-1:0] cap [2][2];
    logic         trail_bad [2];
    vec_t         vecs [6];

    always @(negedge i_clk) begin
        if (if0.o_req) begin
            req_cnt[0]++;
            last_dat[0] = if0.o_dat;
        end
        if (if1.o_req) begin
            req_cnt[1]++;
            last_dat[1] = if1.o_dat;
        end
        if (if0.o_ack) ack_cnt[0]++;
        if (if1.o_ack) ack_cnt[1]++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Word as seen on sdout by a slave with delay dly when only `slot` BCLKs exist.
    function automatic logic [W-1:0] tx_exp(input logic [W-1:0] w, input int slot, input int dly);
        logic [W-1:0] r = '0;
        for (int idx = 0; idx < W; idx++)
            if (idx + dly < slot) r[W-1-idx] = w[W-1-idx];
        return r;
    endfunction

    // Master model: data and LRCK change on BCLK fall, sdout is sampled on BCLK rise.
    task automatic run_frame(input logic [W-1:0] d0, input logic [W-1:0] d1, input int slot,
                             input int dly, input int rst_on, input int rst_off);
        int           wait_ns;
        int           idx;
        int           ix;
        logic [W-1:0] w;
        for (int d = 0; d < 2; d++) begin
            cap[d][0]    = '0;
            cap[d][1]    = '0;
            trail_bad[d] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            w = (c == 0) ? d0 : d1;
            for (int k = 0; k < slot; k++) begin
                wait_ns = HALF;
                idx     = k - dly;
                if (c * slot + k == rst_off) i_rst = 1'b0;
                bclk = 1'b0;
                lrck = (c == 1);
                sdin = (idx >= 0 && idx < W) ? w[W-1-idx] : 1'b1;
                if (c * slot + k == rst_on) begin
                    i_rst = 1'b1;
                    #1;
                    wait_ns = HALF - 1;
                    check("rst_async_odat0", if0.o_dat, 32'h0);
                    check("rst_async_odat1", if1.o_dat, 32'h0);
                    check("rst_async_req", {30'h0, if1.o_req, if0.o_req}, 32'h0);
                    check("rst_async_sdout", {30'h0, sdout}, 32'h0);
                end
                #(wait_ns);
                bclk = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    ix = k - d;
                    if (ix >= 0 && ix < W) cap[d][c][W-1-ix] = sdout[d];
                    else if (sdout[d]) trail_bad[d] = 1'b1;
                end
                #(HALF);
            end
        end
    endtask

    task automatic check_rx(input int d, input int req_before, input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, "_odat"}, last_dat[d], e);
        check({tag, "_req_once"}, req_cnt[d] - req_before, 1);
    endtask

    task automatic reset_recover(input int on_p, input int off_p, input string tag);
        int r0;
        int a0;
        run_frame(16'hDEAD, 16'hBEEF, 16, 0, on_p, off_p);
        r0 = req_cnt[0];
        a0 = ack_cnt[0];
        if0.i_dat = {16'h5A5A, 16'hC001};
        if1.i_dat = {16'h5A5A, 16'hC001};
        exp_q.push_back({16'h39C6, 16'h6C93});
        run_frame(16'h6C93, 16'h39C6, 16, 0, -1, -1);
        check({tag, "_no_partial_req"}, req_cnt[0] - r0, 0);
        check({tag, "_ack"}, ack_cnt[0] - a0, 1);
        check({tag, "_tx_ch0"}, cap[0][0], 16'hC001);
        check({tag, "_tx_ch1"}, cap[0][1], 16'h5A5A);
        run_frame(16'h0001, 16'h8000, 16, 0, -1, -1);
        check_rx(0, r0, tag);
    endtask

    initial begin
        int a_before [2];
        int r_before [2];
        vecs[0] = '{16'hA5C3, 16'h0F0F, 16'h1234, 16'hFEDC, 16, 0};
        vecs[1] = '{16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000, 16, 0};
        vecs[2] = '{16'hA5C3, 16'h0F0F, 16'h1234, 16'hFEDC, 17, 1};
        vecs[3] = '{16'h3C5A, 16'hC3A5, 16'h8000, 16'h0001, 32, 0};
        vecs[4] = '{16'h1357, 16'h9BDF, 16'hAAAA, 16'h5555, 32, 1};
        vecs[5] = '{16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16, 0};

        i_rst     = 1'b1;
        bclk      = 1'b1;
        lrck      = 1'b0;
        sdin      = 1'b0;
        if0.i_dat = '0;
        if1.i_dat = '0;
        repeat (3) @(posedge i_clk);
        #3;
        check("reset_odat0", if0.o_dat, 32'h0);
        check("reset_odat1", if1.o_dat, 32'h0);
        check("reset_req0", {31'h0, if0.o_req}, 32'h0);
        check("reset_req1", {31'h0, if1.o_req}, 32'h0);
        check("reset_ack0", {31'h0, if0.o_ack}, 32'h0);
        check("reset_ack1", {31'h0, if1.o_ack}, 32'h0);
        check("reset_sdout0", {31'h0, sdout[0]}, 32'h0);
        check("reset_sdout1", {31'h0, sdout[1]}, 32'h0);
        i_rst = 1'b0;

        // Warm-up frame: no LRCK 1->0 yet, so no ack, no lock, sdout carries zeros.
        if0.i_dat = {16'h2222, 16'h1111};
        if1.i_dat = {16'h2222, 16'h1111};
        run_frame(16'h9999, 16'h6666, 16, 0, -1, -1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("warm_tx_ch0_dut%0d", d), cap[d][0], 16'h0);
            check($sformatf("warm_tx_ch1_dut%0d", d), cap[d][1], 16'h0);
            check($sformatf("warm_ack_dut%0d", d), ack_cnt[d], 0);
            check($sformatf("warm_req_dut%0d", d), req_cnt[d], 0);
        end

        for (int i = 0; i < 6; i++) begin
            if0.i_dat = {vecs[i].tx1, vecs[i].tx0};
            if1.i_dat = {vecs[i].tx1, vecs[i].tx0};
            for (int d = 0; d < 2; d++) begin
                a_before[d] = ack_cnt[d];
                r_before[d] = req_cnt[d];
            end
            exp_q.push_back({vecs[i].rx1, vecs[i].rx0});
            run_frame(vecs[i].rx0, vecs[i].rx1, vecs[i].slot, vecs[i].dly, -1, -1);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("tx_ch0_dut%0d_vec%0d", d, i), cap[d][0],
                      tx_exp(vecs[i].tx0, vecs[i].slot, d));
                check($sformatf("tx_ch1_dut%0d_vec%0d", d, i), cap[d][1],
                      tx_exp(vecs[i].tx1, vecs[i].slot, d));
                check($sformatf("tx_idle_zero_dut%0d_vec%0d", d, i), {31'h0, trail_bad[d]}, 32'h0);
                check($sformatf("ack_once_dut%0d_vec%0d", d, i), ack_cnt[d] - a_before[d], 1);
            end
            if (i > 0)
                check_rx(vecs[i-1].dly, r_before[vecs[i-1].dly], $sformatf("rx_vec%0d", i - 1));
        end
        r_before[0] = req_cnt[0];
        run_frame(16'h0000, 16'h0000, 16, 0, -1, -1);
        check_rx(vecs[5].dly, r_before[0], "rx_vec5");

        // Reset asserted at a frame start and released inside channel 1.
        reset_recover(0, 22, "rst_ch1_release");
        // Reset asserted inside channel 1 while o_dat holds a frame.
        reset_recover(19, 27, "rst_mid_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
